// File: rtl/rgb_pwm_pkg.sv
// rgb_pwm_pkg: shared types and constants for the RGB PWM fader.
// Build option: RGB_PWM_GAMMA_EN (see rgb_pwm_channel) selects quadratic
// brightness mapping; undefined gives a linear level-to-duty mapping.
package rgb_pwm_pkg;

  // Level and PWM counter width; the SB_RGBA_DRV path is designed around 8 bits.
  localparam int PWM_BITS = 8;

  // 12 MHz / 12000 = 1 ms per fade step.
  localparam int TICK_DIV_DEFAULT = 12000;

  // Tick counter width; covers the full legal TICK_DIV range 2..65535.
  localparam int TICK_W = 16;

  typedef logic [PWM_BITS-1:0] level_t;

  typedef enum logic {
    IDLE = 1'b0,
    FADE = 1'b1
  } fade_state_t;

endpackage

// File: rtl/rgb_pwm_channel.sv
// rgb_pwm_channel: one colour channel of the fader. Holds the current level
// and its target, steps the level one LSB toward the target when told to,
// and produces a registered PWM bit by comparing the (optionally gamma
// mapped) level against the shared free-running PWM counter.
// Build option: RGB_PWM_GAMMA_EN defined -> eff_level = (level*level) >> 8.
module rgb_pwm_channel
  import rgb_pwm_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic [PWM_BITS-1:0] cmd_level,
  input  logic                load_target,
  input  logic                load_level,
  input  logic                step,
  output logic                pwm,
  output logic                at_target,
  output logic                at_target_nxt,
  output logic                cmd_match
);

  level_t level_q;
  level_t target_q;
  level_t level_step;
  level_t eff_level;
  logic   pwm_p1;

  // One LSB toward the target; never overshoots, so no wrap 0 <-> 255.
  function automatic level_t step_toward(input level_t cur, input level_t tgt);
    logic signed [PWM_BITS:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff == '0) begin
      return cur;
    end else if (diff[PWM_BITS]) begin
      return cur - level_t'(1);
    end else begin
      return cur + level_t'(1);
    end
  endfunction

`ifdef RGB_PWM_GAMMA_EN
  // Quadratic perceptual mapping: full 16-bit square, keep the top byte.
  function automatic level_t gamma_map(input level_t lvl);
    logic [2*PWM_BITS-1:0] prod;
    prod = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl};
    return level_t'(prod >> PWM_BITS);
  endfunction

  assign eff_level = gamma_map(level_q);
`else
  assign eff_level = level_q;
`endif

  assign level_step    = step_toward(level_q, target_q);
  assign at_target     = (level_q == target_q);
  assign at_target_nxt = (level_step == target_q);
  assign cmd_match     = (cmd_level == level_q);
  assign pwm           = pwm_p1;

  // Level/target registers: an instant load overrides any fade step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q  <= '0;
      target_q <= '0;
    end else begin
      if (load_target) begin
        target_q <= cmd_level;
      end
      if (load_level) begin
        level_q <= cmd_level;
      end else if (step) begin
        level_q <= level_step;
      end
    end
  end

  // Registered compare: high while the shared counter is below the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_p1 <= 1'b0;
    end else begin
      pwm_p1 <= (pwm_cnt < eff_level);
    end
  end

endmodule

// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: three-channel PWM generator with a timed fade engine,
// feeding RGB0PWM/RGB1PWM/RGB2PWM of SB_RGBA_DRV. Accepts a target colour on
// a valid/ready interface and either jumps to it or fades one LSB per tick.
// Build option: RGB_PWM_GAMMA_EN enables gamma mapping inside each channel;
// handshake, fade and done timing are the same in both builds.
module rgb_pwm_fader
  import rgb_pwm_pkg::*;
#(
  // Clock cycles per fade tick; legal range 2..65535.
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic                hw_clk,
  input  logic                rst_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_instant,
  input  logic [PWM_BITS-1:0] cmd_r,
  input  logic [PWM_BITS-1:0] cmd_g,
  input  logic [PWM_BITS-1:0] cmd_b,
  output logic                pwm_r,
  output logic                pwm_g,
  output logic                pwm_b,
  output logic                busy,
  output logic                done
);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

  fade_state_t       state_q;
  fade_state_t       state_nxt;
  level_t            pwm_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              done_q;
  logic              done_nxt;
  logic              cmd_accept;
  logic              load_target;
  logic              load_level;
  logic              step;
  logic [2:0]        at_target;
  logic [2:0]        at_target_nxt;
  logic [2:0]        cmd_match;
  logic [2:0]        pwm_bits;
  level_t            cmd_lvl [3];

  assign cmd_lvl[0] = cmd_r;
  assign cmd_lvl[1] = cmd_g;
  assign cmd_lvl[2] = cmd_b;

  assign tick       = (tick_cnt == TICK_LAST);
  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q == FADE);
  assign cmd_accept = cmd_valid && cmd_ready;
  assign done       = done_q;
  assign pwm_r      = pwm_bits[0];
  assign pwm_g      = pwm_bits[1];
  assign pwm_b      = pwm_bits[2];

  // Shared 8-bit PWM counter, free-running with natural wrap 255 -> 0.
  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + level_t'(1);
    end
  end

  // Fade tick divider; free-running and never restarted by commands.
  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  // FSM state and the registered one-cycle done pulse.
  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      done_q  <= done_nxt;
    end
  end

  // Next state, channel load/step strobes and done; ticks only act in FADE,
  // so a tick coinciding with command acceptance is ignored.
  always_comb begin
    state_nxt   = state_q;
    done_nxt    = 1'b0;
    load_target = 1'b0;
    load_level  = 1'b0;
    step        = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_accept) begin
          load_target = 1'b1;
          if (cmd_instant) begin
            load_level = 1'b1;
            done_nxt   = 1'b1;
          end else if (&cmd_match) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = FADE;
          end
        end
      end
      FADE: begin
        // Defensive exit: FADE is only entered with a mismatch, so this
        // branch normally never fires.
        if (&at_target) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end else if (tick) begin
          step = 1'b1;
          if (&at_target_nxt) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    rgb_pwm_channel u_ch (
      .clk           (hw_clk),
      .rst_n         (rst_n),
      .pwm_cnt       (pwm_cnt),
      .cmd_level     (cmd_lvl[ch]),
      .load_target   (load_target),
      .load_level    (load_level),
      .step          (step),
      .pwm           (pwm_bits[ch]),
      .at_target     (at_target[ch]),
      .at_target_nxt (at_target_nxt[ch]),
      .cmd_match     (cmd_match[ch])
    );
  end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// tb_rgb_pwm_fader: directed bench for rgb_pwm_fader with a cycle-level
// behavioural model (levels, targets, fade flag) and per-cycle compare.
// Honours RGB_PWM_GAMMA_EN for the expected duty values.
module tb_rgb_pwm_fader;

  localparam int TDIV = 4;

`ifdef RGB_PWM_GAMMA_EN
  localparam int E128 = 64;
  localparam int E255 = 254;
  localparam int E15  = 0;
  localparam int E16  = 1;
`else
  localparam int E128 = 128;
  localparam int E255 = 255;
  localparam int E15  = 15;
  localparam int E16  = 16;
`endif

  logic       hw_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_instant = 1'b0;
  logic [7:0] cmd_r = 8'd0;
  logic [7:0] cmd_g = 8'd0;
  logic [7:0] cmd_b = 8'd0;
  logic       cmd_ready;
  logic       pwm_r;
  logic       pwm_g;
  logic       pwm_b;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  int m_cyc = 0;
  int m_lvl [3] = '{0, 0, 0};
  int m_tgt [3] = '{0, 0, 0};
  int m_cmd [3] = '{0, 0, 0};
  bit m_fade = 1'b0;
  bit m_done = 1'b0;
  bit m_pwm [3] = '{1'b0, 1'b0, 1'b0};

  rgb_pwm_fader #(.TICK_DIV(TDIV)) dut (
    .hw_clk      (hw_clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_instant (cmd_instant),
    .cmd_r       (cmd_r),
    .cmd_g       (cmd_g),
    .cmd_b       (cmd_b),
    .pwm_r       (pwm_r),
    .pwm_g       (pwm_g),
    .pwm_b       (pwm_b),
    .busy        (busy),
    .done        (done)
  );

  always #5 hw_clk = ~hw_clk;

  function automatic int eff(input int l);
`ifdef RGB_PWM_GAMMA_EN
    return (l * l) / 256;
`else
    return l;
`endif
  endfunction

  function automatic int max_gap();
    int g;
    g = 0;
    for (int i = 0; i < 3; i++) begin
      if (m_tgt[i] - m_lvl[i] > g) g = m_tgt[i] - m_lvl[i];
      if (m_lvl[i] - m_tgt[i] > g) g = m_lvl[i] - m_tgt[i];
    end
    return g;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: duty from cycle count, command rules, one LSB per tick while fading.
  always @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cyc  = 0;
      m_fade = 1'b0;
      m_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_lvl[i] = 0;
        m_tgt[i] = 0;
        m_pwm[i] = 1'b0;
      end
    end else begin
      for (int i = 0; i < 3; i++) m_pwm[i] = ((m_cyc % 256) < eff(m_lvl[i]));
      m_done = 1'b0;
      m_cmd[0] = int'(cmd_r);
      m_cmd[1] = int'(cmd_g);
      m_cmd[2] = int'(cmd_b);
      if (!m_fade) begin
        if (cmd_valid) begin
          for (int i = 0; i < 3; i++) m_tgt[i] = m_cmd[i];
          if (cmd_instant) begin
            for (int i = 0; i < 3; i++) m_lvl[i] = m_cmd[i];
            m_done = 1'b1;
          end else if (max_gap() == 0) begin
            m_done = 1'b1;
          end else begin
            m_fade = 1'b1;
          end
        end
      end else if ((m_cyc % TDIV) == TDIV - 1) begin
        for (int i = 0; i < 3; i++) begin
          if (m_lvl[i] < m_tgt[i]) m_lvl[i] = m_lvl[i] + 1;
          else if (m_lvl[i] > m_tgt[i]) m_lvl[i] = m_lvl[i] - 1;
        end
        if (max_gap() == 0) begin
          m_fade = 1'b0;
          m_done = 1'b1;
        end
      end
      m_cyc++;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge hw_clk) begin
    if (rst_n && chk_en) begin
      check("pwm_r", int'(pwm_r), int'(m_pwm[0]));
      check("pwm_g", int'(pwm_g), int'(m_pwm[1]));
      check("pwm_b", int'(pwm_b), int'(m_pwm[2]));
      check("done", int'(done), int'(m_done));
      check("busy", int'(busy), int'(m_fade));
      check("cmd_ready", int'(cmd_ready), int'(!m_fade));
    end
  end

  task automatic send(input bit inst, input int r, input int g, input int b);
    bit ok;
    ok = 1'b0;
    cmd_instant = inst;
    cmd_r = 8'(r);
    cmd_g = 8'(g);
    cmd_b = 8'(b);
    cmd_valid = 1'b1;
    for (int n = 0; n < 2000; n++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        @(negedge hw_clk);
        break;
      end
      @(negedge hw_clk);
    end
    cmd_valid = 1'b0;
    if (!ok) check("accept_timeout", 0, 1);
  endtask

  task automatic count_win(input int n, output int cr, output int cg, output int cb,
                           output int cd, output int cbz);
    cr = 0; cg = 0; cb = 0; cd = 0; cbz = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge hw_clk);
      cr += int'(pwm_r);
      cg += int'(pwm_g);
      cb += int'(pwm_b);
      cd += int'(done);
      cbz += int'(busy);
    end
  endtask

  initial begin
    int cr, cg, cb, cd, cbz;
    int busy_cnt, rdy_cnt;
    bit got;

    // Reset held: reset values
    repeat (3) @(negedge hw_clk);
    check("rst_pwm_r", int'(pwm_r), 0);
    check("rst_pwm_g", int'(pwm_g), 0);
    check("rst_pwm_b", int'(pwm_b), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_ready", int'(cmd_ready), 1);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;

    // Idle after release: no PWM activity for 1024 cycles
    count_win(1024, cr, cg, cb, cd, cbz);
    check("idle_pwm_high", cr + cg + cb, 0);
    check("idle_busy", cbz, 0);
    check("idle_done", cd, 0);
    check("idle_ready", int'(cmd_ready), 1);

    // Instant 128/0/255
    send(1'b1, 128, 0, 255);
    check("inst_done", int'(done), 1);
    check("inst_busy", int'(busy), 0);
    count_win(256, cr, cg, cb, cd, cbz);
    check("inst_duty_r", cr, E128);
    check("inst_duty_g", cg, 0);
    check("inst_duty_b", cb, E255);
    check("inst_done_once", cd, 0);
    check("inst_busy_win", cbz, 0);

    // Instant 15/16/0: gamma threshold edge
    send(1'b1, 15, 16, 0);
    check("inst2_done", int'(done), 1);
    count_win(256, cr, cg, cb, cd, cbz);
    check("inst2_duty_r", cr, E15);
    check("inst2_duty_g", cg, E16);
    check("inst2_duty_b", cb, 0);

    // Back to zero, then a fade command equal to current levels
    send(1'b1, 0, 0, 0);
    @(negedge hw_clk);
    send(1'b0, 0, 0, 0);
    check("eq_done", int'(done), 1);
    check("eq_busy", int'(busy), 0);
    @(negedge hw_clk);
    check("eq_done_once", int'(done), 0);

    // Fade 0 -> 3/1/0, accepted on a tick cycle, with a second command held
    got = 1'b0;
    for (int n = 0; n < 2 * TDIV; n++) begin
      if ((m_cyc % TDIV) == TDIV - 1) begin
        got = 1'b1;
        break;
      end
      @(negedge hw_clk);
    end
    check("align_tick", int'(got), 1);
    check("fade1_ready_pre", int'(cmd_ready), 1);
    cmd_instant = 1'b0;
    cmd_r = 8'd3; cmd_g = 8'd1; cmd_b = 8'd0;
    cmd_valid = 1'b1;
    @(negedge hw_clk);
    cmd_r = 8'd0; cmd_g = 8'd0; cmd_b = 8'd0;
    check("fade1_busy_entry", int'(busy), 1);
    busy_cnt = 0; rdy_cnt = 0; got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      busy_cnt += int'(busy);
      rdy_cnt += int'(cmd_ready);
      @(negedge hw_clk);
    end
    check("fade1_done_seen", int'(got), 1);
    check("fade1_busy_cycles", busy_cnt, 3 * TDIV);
    check("fade1_ready_low", rdy_cnt, 0);
    check("fade1_ready_at_done", int'(cmd_ready), 1);
    check("fade1_busy_at_done", int'(busy), 0);
    check("model_lvl_r", m_lvl[0], 3);
    check("model_lvl_g", m_lvl[1], 1);
    @(negedge hw_clk);
    cmd_valid = 1'b0;
    check("fade2_busy_entry", int'(busy), 1);
    check("fade2_done_low", int'(done), 0);
    busy_cnt = 0; got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
      busy_cnt += int'(busy);
      @(negedge hw_clk);
    end
    check("fade2_done_seen", int'(got), 1);
    check("fade2_busy_cycles", busy_cnt, 3 * TDIV - 1);
    check("model_lvl_r0", m_lvl[0], 0);
    @(negedge hw_clk);
    check("fade2_done_once", int'(done), 0);

    // Reset in the middle of a fade, at level 2
    send(1'b0, 5, 5, 5);
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (m_lvl[0] == 2) begin
        got = 1'b1;
        break;
      end
      @(negedge hw_clk);
    end
    check("mid_level2", int'(got), 1);
    check("mid_busy_pre", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_pwm", int'(pwm_r) + int'(pwm_g) + int'(pwm_b), 0);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_done", int'(done), 0);
    check("mid_rst_ready", int'(cmd_ready), 1);
    @(negedge hw_clk);
    #2 rst_n = 1'b1;
    count_win(512, cr, cg, cb, cd, cbz);
    check("post_rst_pwm", cr + cg + cb, 0);
    check("post_rst_busy", cbz, 0);
    check("post_rst_done", cd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
